// File: rtl/lagarto_fpu_xcpt_arbiter.sv
// Round-robin arbiter sharing one lagarto_fpu_xcpt unit between N_LANES vector FP
// lanes, with a one-entry response slot and the sticky fflags accumulator.
module lagarto_fpu_xcpt_arbiter #(
  parameter  int N_LANES = 4,
  localparam int LW      = $clog2(N_LANES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_LANES-1:0]   req_valid_i,
  output logic [N_LANES-1:0]   req_ready_o,
  input  logic [12*N_LANES-1:0] req_exp_i,
  input  logic [55*N_LANES-1:0] req_mant_i,
  input  logic [N_LANES-1:0]   req_ovf_round_i,
  input  logic [N_LANES-1:0]   req_invalid_i,
  input  logic [N_LANES-1:0]   req_dz_i,
  output logic [11:0]          xcpt_exponent_o,
  output logic [54:0]          xcpt_mantissa_o,
  output logic                 xcpt_ovf_round_o,
  output logic                 xcpt_invalid_o,
  input  logic                 xcpt_underflow_i,
  input  logic                 xcpt_overflow_i,
  input  logic                 xcpt_inexact_i,
  input  logic                 xcpt_zero_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [LW-1:0]        resp_lane_o,
  output logic [4:0]           resp_flags_o,
  output logic                 resp_zero_o,
  input  logic                 flush_i,
  input  logic                 fflags_clr_i,
  output logic [4:0]           fflags_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [4:0]    flags_q, flags_d;
  logic          zero_q, zero_d;
  logic [4:0]    fflags_q, fflags_d;

  logic [LW-1:0] pick;
  logic          any_valid;
  logic          slot_free;
  logic          grant;
  logic          accept;

  // First valid lane at or above ptr, wrapping modulo N_LANES.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_LANES) idx = idx - N_LANES;
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        pick      = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    xcpt_exponent_o  = '0;
    xcpt_mantissa_o  = '0;
    xcpt_ovf_round_o = 1'b0;
    xcpt_invalid_o   = 1'b0;
    if (any_valid) begin
      xcpt_exponent_o  = req_exp_i[12*pick +: 12];
      xcpt_mantissa_o  = req_mant_i[55*pick +: 55];
      xcpt_ovf_round_o = req_ovf_round_i[pick];
      xcpt_invalid_o   = req_invalid_i[pick];
    end
  end

  assign slot_free   = (state_q == EMPTY) || resp_ready_i;
  assign grant       = any_valid && slot_free && !flush_i;
  assign accept      = (state_q == FULL) && resp_ready_i && !flush_i;
  assign req_ready_o = grant ? (N_LANES'(1) << pick) : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lane_d   = lane_q;
    flags_d  = flags_q;
    zero_d   = zero_q;
    fflags_d = fflags_q;

    // A clear in the accept cycle wipes old flags but keeps the ones being accepted.
    if (accept)
      fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | flags_q;
    else if (fflags_clr_i)
      fflags_d = 5'b0;

    if (flush_i) begin
      state_d = EMPTY;
    end else if (grant) begin
      state_d = FULL;
      ptr_d   = (pick == LW'(N_LANES - 1)) ? '0 : pick + LW'(1);
      lane_d  = pick;
      flags_d = {req_invalid_i[pick], req_dz_i[pick], xcpt_overflow_i,
                 xcpt_underflow_i, xcpt_inexact_i};
      zero_d  = xcpt_zero_i;
    end else if ((state_q == FULL) && resp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      lane_q   <= '0;
      flags_q  <= '0;
      zero_q   <= 1'b0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lane_q   <= lane_d;
      flags_q  <= flags_d;
      zero_q   <= zero_d;
      fflags_q <= fflags_d;
    end
  end

  assign resp_valid_o = (state_q == FULL);
  assign resp_lane_o  = lane_q;
  assign resp_flags_o = flags_q;
  assign resp_zero_o  = zero_q;
  assign fflags_o     = fflags_q;

endmodule

// File: tb/tb_lagarto_fpu_xcpt_arbiter.sv
// Self-checking bench for lagarto_fpu_xcpt_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level model of the arbiter.
module tb_lagarto_fpu_xcpt_arbiter;
  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [12*N-1:0] req_exp_i = '0;
  logic [55*N-1:0] req_mant_i = '0;
  logic [N-1:0]    req_ovf_round_i = '0;
  logic [N-1:0]    req_invalid_i = '0;
  logic [N-1:0]    req_dz_i = '0;
  logic [11:0]     xcpt_exponent_o;
  logic [54:0]     xcpt_mantissa_o;
  logic            xcpt_ovf_round_o;
  logic            xcpt_invalid_o;
  logic            xcpt_underflow_i;
  logic            xcpt_overflow_i;
  logic            xcpt_inexact_i;
  logic            xcpt_zero_i;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b0;
  logic [1:0]      resp_lane_o;
  logic [4:0]      resp_flags_o;
  logic            resp_zero_o;
  logic            flush_i = 1'b0;
  logic            fflags_clr_i = 1'b0;
  logic [4:0]      fflags_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int         mPtr;
  bit         mFull;
  int         mLane;
  logic [4:0] mFlags;
  bit         mZero;
  logic [4:0] mFflags;

  always #5 clk_i = ~clk_i;

  // Simplified stand-in for the shared exception unit.
  assign xcpt_overflow_i  = (xcpt_exponent_o == 12'h7FF) || xcpt_ovf_round_o;
  assign xcpt_underflow_i = (xcpt_exponent_o == 12'h000) && (xcpt_mantissa_o != '0);
  assign xcpt_inexact_i   = |xcpt_mantissa_o[1:0];
  assign xcpt_zero_i      = (xcpt_exponent_o == 12'h000) && (xcpt_mantissa_o == '0);

  lagarto_fpu_xcpt_arbiter #(.N_LANES(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_exp_i(req_exp_i), .req_mant_i(req_mant_i),
    .req_ovf_round_i(req_ovf_round_i), .req_invalid_i(req_invalid_i), .req_dz_i(req_dz_i),
    .xcpt_exponent_o(xcpt_exponent_o), .xcpt_mantissa_o(xcpt_mantissa_o),
    .xcpt_ovf_round_o(xcpt_ovf_round_o), .xcpt_invalid_o(xcpt_invalid_o),
    .xcpt_underflow_i(xcpt_underflow_i), .xcpt_overflow_i(xcpt_overflow_i),
    .xcpt_inexact_i(xcpt_inexact_i), .xcpt_zero_i(xcpt_zero_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_lane_o(resp_lane_o), .resp_flags_o(resp_flags_o), .resp_zero_o(resp_zero_o),
    .flush_i(flush_i), .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int rrPick(int ptr);
    for (int k = 0; k < N; k++)
      if (req_valid_i[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [4:0] laneFlags(int l);
    logic [11:0] e;
    logic [54:0] m;
    e = req_exp_i[12*l +: 12];
    m = req_mant_i[55*l +: 55];
    return {req_invalid_i[l], req_dz_i[l], (e == 12'h7FF) || req_ovf_round_i[l],
            (e == 12'h000) && (m != '0), m[1] | m[0]};
  endfunction

  function automatic bit laneZero(int l);
    return (req_exp_i[12*l +: 12] == 12'h000) && (req_mant_i[55*l +: 55] == '0);
  endfunction

  task automatic modelReset();
    mPtr = 0; mFull = 0; mLane = 0; mFlags = '0; mZero = 0; mFflags = '0;
  endtask

  task automatic setLane(input int l, input logic [11:0] e, input logic [54:0] m,
                         input bit ovf, input bit inv, input bit dz, input bit v);
    req_exp_i[12*l +: 12] = e;
    req_mant_i[55*l +: 55] = m;
    req_ovf_round_i[l] = ovf;
    req_invalid_i[l]   = inv;
    req_dz_i[l]        = dz;
    req_valid_i[l]     = v;
  endtask

  task automatic clearReq();
    for (int l = 0; l < N; l++) setLane(l, 12'h0, 55'h0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check everything against the model, clock, advance the model.
  task automatic applyStimulus();
    int g;
    bit grant;
    logic [3:0] expReady;
    logic [4:0] gFlags;
    bit gZero;
    #1;
    g        = rrPick(mPtr);
    grant    = (g >= 0) && (!mFull || resp_ready_i) && !flush_i;
    expReady = grant ? (4'b0001 << g) : 4'b0000;
    gFlags   = (g >= 0) ? laneFlags(g) : 5'b0;
    gZero    = (g >= 0) ? laneZero(g) : 1'b0;
    checkOutput("req_ready", req_ready_o, expReady);
    checkOutput("xcpt_exp", xcpt_exponent_o, (g >= 0) ? req_exp_i[12*g +: 12] : 12'h0);
    checkOutput("xcpt_mant", xcpt_mantissa_o, (g >= 0) ? req_mant_i[55*g +: 55] : 55'h0);
    checkOutput("resp_valid", resp_valid_o, mFull);
    if (mFull) begin
      checkOutput("resp_lane", resp_lane_o, mLane);
      checkOutput("resp_flags", resp_flags_o, mFlags);
      checkOutput("resp_zero", resp_zero_o, mZero);
    end
    checkOutput("fflags", fflags_o, mFflags);
    @(posedge clk_i);
    if (mFull && resp_ready_i && !flush_i)
      mFflags = (fflags_clr_i ? 5'b0 : mFflags) | mFlags;
    else if (fflags_clr_i)
      mFflags = 5'b0;
    if (flush_i) mFull = 0;
    else if (grant) begin
      mFull = 1; mLane = g; mFlags = gFlags; mZero = gZero; mPtr = (g + 1) % N;
    end else if (mFull && resp_ready_i) mFull = 0;
    @(negedge clk_i);
  endtask

  initial begin
    modelReset();
    #2;
    checkOutput("reset_resp_valid", resp_valid_o, 1'b0);
    checkOutput("reset_fflags", fflags_o, 5'b0);
    checkOutput("reset_resp_flags", resp_flags_o, 5'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] single request on lane 2");
    resp_ready_i = 1'b1;
    setLane(2, 12'h7FF, 55'h0, 0, 0, 0, 1);
    applyStimulus();
    clearReq();
    #1;
    checkOutput("single_lane", resp_lane_o, 2'd2);
    checkOutput("single_flags", resp_flags_o, 5'b00100);
    applyStimulus();
    checkOutput("single_fflags", fflags_o, 5'b00100);
    applyStimulus();

    $display("[TB] fairness with all lanes valid");
    for (int l = 0; l < N; l++) setLane(l, 12'h100 + 12'(l), 55'(l), 0, 0, 0, 1);
    repeat (6) applyStimulus();

    $display("[TB] backpressure");
    resp_ready_i = 1'b0;
    repeat (4) applyStimulus();
    resp_ready_i = 1'b1;
    repeat (2) applyStimulus();
    clearReq();
    applyStimulus();

    $display("[TB] sticky accumulate and clear");
    fflags_clr_i = 1'b1;
    applyStimulus();
    fflags_clr_i = 1'b0;
    setLane(0, 12'h123, 55'h1, 0, 0, 0, 1);
    applyStimulus();
    setLane(0, 12'h000, 55'h1, 0, 0, 0, 1);
    applyStimulus();
    clearReq();
    applyStimulus();
    checkOutput("sticky_ufnx", fflags_o, 5'b00011);
    setLane(1, 12'h001, 55'h0, 0, 1, 0, 1);
    applyStimulus();
    clearReq();
    fflags_clr_i = 1'b1;
    applyStimulus();
    fflags_clr_i = 1'b0;
    checkOutput("clear_with_accept", fflags_o, 5'b10000);

    $display("[TB] flush");
    setLane(0, 12'h010, 55'h0, 1, 0, 0, 1);
    applyStimulus();
    clearReq();
    flush_i = 1'b1;
    applyStimulus();
    flush_i = 1'b0;
    checkOutput("flush_valid", resp_valid_o, 1'b0);
    checkOutput("flush_fflags", fflags_o, 5'b10000);
    applyStimulus();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < N; l++) begin
        logic [11:0] e;
        logic [54:0] m;
        case ($urandom_range(0, 3))
          0: e = 12'h000;
          1: e = 12'h7FF;
          default: e = 12'($urandom);
        endcase
        m = ($urandom_range(0, 3) == 0) ? 55'h0 : {23'($urandom), $urandom};
        setLane(l, e, m, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      end
      resp_ready_i = $urandom_range(0, 3) != 0;
      flush_i      = $urandom_range(0, 19) == 0;
      fflags_clr_i = $urandom_range(0, 19) == 0;
      applyStimulus();
    end
    flush_i = 1'b0;
    fflags_clr_i = 1'b0;

    $display("[TB] asynchronous reset while full");
    clearReq();
    resp_ready_i = 1'b0;
    setLane(3, 12'h7FF, 55'h3, 0, 1, 1, 1);
    applyStimulus();
    applyStimulus();
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("areset_valid", resp_valid_o, 1'b0);
    checkOutput("areset_lane", resp_lane_o, 2'd0);
    checkOutput("areset_flags", resp_flags_o, 5'b0);
    checkOutput("areset_zero", resp_zero_o, 1'b0);
    checkOutput("areset_fflags", fflags_o, 5'b0);
    modelReset();
    @(negedge clk_i);
    rst_i = 1'b0;
    resp_ready_i = 1'b1;
    for (int l = 0; l < N; l++) setLane(l, 12'h200, 55'h4, 0, 0, 0, 1);
    #1;
    checkOutput("first_grant_after_reset", req_ready_o, 4'b0001);
    applyStimulus();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout reached before end of test");
    $fatal(1, "[TB] timeout");
  end

endmodule
